rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Sharing controller for the register-file write port. Arbitrates the single write port (WE3/WD3/A3) between the in-order writeback stage and the multi-cycle mul/div result path. Buffers up to two mul/div results and keeps a 32-entry pending-destination scoreboard, so decode stalls on RAW and WAW hazards against outstanding mul/div writes. Sits between the writeback stage, the mul/div unit, the hazard unit and `regfile`.

## Interface
- `DATA_WIDTH`, 32: register data width.
- `FIFO_DEPTH`, 2: mul/div result buffer entries (power of two).
- `STARVE_LIMIT`, 4: cycles a buffered result may wait before the arbiter forces a writeback bubble.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_we_i` in 3: writeback write-enable code (000 none, 001 word, 010 lh, 011 lb, 110 lhu, 111 lbu).
- `wb_rd_i` in 5: writeback destination register.
- `wb_data_i` in DATA_WIDTH: writeback data.
- `md_valid_i` in 1: mul/div result valid.
- `md_rd_i` in 5: mul/div destination register.
- `md_data_i` in DATA_WIDTH: mul/div result.
- `md_ready_o` out 1: arbiter accepts a mul/div result this cycle.
- `issue_valid_i` in 1: a mul/div instruction issues this cycle.
- `issue_rd_i` in 5: its destination register.
- `dec_rs1_i`, `dec_rs2_i`, `dec_rd_i` in 5 each: operand and destination registers of the instruction in decode.
- `stall_o` out 1: decode must stall (hazard).
- `wb_hold_o` out 1: pipeline must present `wb_we_i`=000 next cycle.
- `WE3` out 3, `WD3` out DATA_WIDTH, `A3` out 5: regfile write port.

## Operation
- Write-port priority each cycle:
  1. Writeback, if `wb_we_i`≠000 and `wb_rd_i`≠0. Drive the code, data and register unchanged.
  2. Otherwise the FIFO head, if the FIFO is non-empty. Drive `WE3`=001.
  3. Otherwise a bypass of `md_data_i`, if `md_valid_i`. Drive `WE3`=001; the result does not enter the FIFO.
  4. Otherwise `WE3`=000, with `WD3` and `A3` driven to 0.
- Writes to x0 from either source never reach the port (`WE3`=000). A mul/div result with rd=0 is still accepted and dropped.
- `md_ready_o` = FIFO not full. A result is accepted when `md_valid_i && md_ready_o`.
  - An accepted result that is not bypassed is pushed into the FIFO.
  - When full, pop and push in the same cycle are allowed only if a pop occurs; `md_ready_o` is computed from the registered count, so it stays low when full.
- Scoreboard `pending[31:0]`:
  - Set bit `issue_rd_i` when `issue_valid_i` and `issue_rd_i`≠0.
  - Clear a bit when its mul/div result is written to the port, or when the result is dropped because rd=0.
  - If set and clear target the same bit in one cycle, set wins.
- `stall_o` = `pending[dec_rs1_i] | pending[dec_rs2_i] | pending[dec_rd_i]`. Index 0 always reads 0.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Resets on a pop or when the FIFO is empty.
  - `wb_hold_o` is asserted while count ≥ STARVE_LIMIT-1 and the FIFO is non-empty.
- Protocol violations, flagged by a simulation assertion only:
  - `issue_valid_i` with `issue_rd_i` already pending.
  - `wb_we_i`≠000 in the cycle after `wb_hold_o`.

## Timing
- Write-port outputs are combinational from the inputs and registered state. A writeback or bypass reaches `regfile` in the same cycle, and the regfile commits it on that cycle's falling edge.
- FIFO, scoreboard and starvation counter update on the rising edge of `clk`.
- A result pushed in cycle N can be popped no earlier than N+1.
- A pending bit set at edge N drives `stall_o` from cycle N+1. A bit cleared at edge N releases `stall_o` from N+1.
  - The write itself completes on the falling edge of cycle N, before decode reads in N+1.
- `wb_hold_o` is a registered-state function; the pipeline honours it in the following cycle.
- Reset (asynchronous assert, synchronous deassert):
  - FIFO empty, `pending`=0, counter=0.
  - Outputs: `md_ready_o`=1, `stall_o`=0, `wb_hold_o`=0, `WE3`=000, `WD3`=0, `A3`=0.
- Reset mid-operation discards buffered results and pending bits. The mul/div unit is reset by the same `rst_n`.

## Structure
- Shared package `rf_pkg`:
  - `we3_t` enum with the six write codes.
  - `REG_COUNT`=32 and `REG_ADDR_W`=5.
  - `md_result_t` struct {rd, data}.
- Sub-module `md_result_fifo`: FIFO_DEPTH-entry synchronous FIFO of `md_result_t`, with push/pop, `full`/`empty` and a registered count, plus wrap-around pointers.
- All arbitration, scoreboard and starvation logic stays in the top module.

## Test plan
- **Writeback priority.** WB writes x5=0x1234 (`WE3`=001) while `md_valid_i` carries x6=0xBEEF.
  - Port shows x5; x6 is buffered; `md_ready_o` stays 1.
  - Next idle cycle, port shows `WE3`=001, `A3`=6, `WD3`=0xBEEF.
- **Bypass and scoreboard.** Issue rd=7, then decode rs1=7.
  - `stall_o`=1 from the next cycle.
  - An md result x7=42 with no WB activity is written the same cycle; `stall_o`=0 the cycle after.
- **FIFO full.** WB writes every cycle while two md results arrive.
  - `md_ready_o`=0 after the second result.
  - `wb_hold_o`=1 after STARVE_LIMIT-1 waiting cycles; the bubble drains the head, and `md_ready_o` returns to 1.
- **x0 handling.** WB `wb_rd_i`=0 with `WE3` code 011, and an md result with rd=0.
  - `WE3` stays 000 throughout; the md result is accepted, and `pending` is unchanged.
- **Load codes.** WB codes 010/011/110/111 pass through unchanged on `WE3` with `A3`/`WD3` intact.
- **Reset mid-operation.** Two results buffered and pending bits 3 and 9 set; pulse `rst_n` low asynchronously.
  - All outputs take reset values immediately.
  - After release, `stall_o`=0 for dec_rs1=3.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: write-enable codes,
// register-file geometry and the buffered mul/div result record.
package rf_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned RF_DATA_W  = 32;

  typedef enum logic [2:0] {
    WE_NONE = 3'b000,
    WE_WORD = 3'b001,
    WE_LH   = 3'b010,
    WE_LB   = 3'b011,
    WE_LHU  = 3'b110,
    WE_LBU  = 3'b111
  } we3_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0]  data;
  } md_result_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the pipeline/mul-div side (master) and the
// register-file write arbiter (slave), including the regfile write port.
interface rf_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [2:0]            wb_we_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [DATA_WIDTH-1:0] wb_data_i;

  logic                  md_valid_i;
  logic [REG_ADDR_W-1:0] md_rd_i;
  logic [DATA_WIDTH-1:0] md_data_i;
  logic                  md_ready_o;

  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;

  logic [REG_ADDR_W-1:0] dec_rs1_i;
  logic [REG_ADDR_W-1:0] dec_rs2_i;
  logic [REG_ADDR_W-1:0] dec_rd_i;

  logic                  stall_o;
  logic                  wb_hold_o;

  logic [2:0]            WE3;
  logic [DATA_WIDTH-1:0] WD3;
  logic [REG_ADDR_W-1:0] A3;

  modport master (
    output wb_we_i, wb_rd_i, wb_data_i,
    output md_valid_i, md_rd_i, md_data_i,
    input  md_ready_o,
    output issue_valid_i, issue_rd_i,
    output dec_rs1_i, dec_rs2_i, dec_rd_i,
    input  stall_o, wb_hold_o,
    input  WE3, WD3, A3
  );

  modport slave (
    input  wb_we_i, wb_rd_i, wb_data_i,
    input  md_valid_i, md_rd_i, md_data_i,
    output md_ready_o,
    input  issue_valid_i, issue_rd_i,
    input  dec_rs1_i, dec_rs2_i, dec_rd_i,
    output stall_o, wb_hold_o,
    output WE3, WD3, A3
  );

endinterface

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO holding mul/div results awaiting a free
// register-file write slot. DEPTH must be a power of two (>= 2).
module md_result_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = md_result_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single regfile write port between in-order writeback and the
// mul/div result path; tracks outstanding mul/div destinations for hazard stalls.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned     SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] HOLD_AT = SC_W'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                head;
  entry_t                md_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  wb_active;
  logic                  md_ready;
  logic                  accept;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  wb_hold;
  logic [REG_COUNT-1:0]  pending;
  logic [REG_COUNT-1:0]  set_mask;
  logic [REG_COUNT-1:0]  clr_mask;
  logic [SC_W-1:0]       starve_cnt;
  logic [2:0]            we3;
  logic [DATA_WIDTH-1:0] wd3;
  logic [REG_ADDR_W-1:0] a3;

  assign md_entry = '{rd: bus.md_rd_i, data: bus.md_data_i};

  md_result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (md_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // rd=0 results are accepted but never stored, so the FIFO head is always a real register.
  always_comb begin
    wb_active = (bus.wb_we_i != WE_NONE) && (bus.wb_rd_i != '0);
    md_ready  = !fifo_full;
    accept    = bus.md_valid_i && md_ready;
    pop       = !wb_active && !fifo_empty;
    bypass    = !wb_active && fifo_empty && accept;
    push      = accept && !bypass && (bus.md_rd_i != '0);
  end

  always_comb begin
    we3 = WE_NONE;
    wd3 = '0;
    a3  = '0;
    if (wb_active) begin
      we3 = bus.wb_we_i;
      wd3 = bus.wb_data_i;
      a3  = bus.wb_rd_i;
    end else if (pop) begin
      we3 = WE_WORD;
      wd3 = head.data;
      a3  = head.rd;
    end else if (bypass && (bus.md_rd_i != '0)) begin
      we3 = WE_WORD;
      wd3 = bus.md_data_i;
      a3  = bus.md_rd_i;
    end
  end

  // Clearing bit 0 on a dropped rd=0 result is harmless: it is never set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pop)    clr_mask[head.rd]      = 1'b1;
    if (bypass) clr_mask[bus.md_rd_i]  = 1'b1;
    if (bus.issue_valid_i && (bus.issue_rd_i != '0))
      set_mask[bus.issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      starve_cnt <= '0;
    else if (fifo_empty || pop)      starve_cnt <= '0;
    else if (starve_cnt < HOLD_AT)   starve_cnt <= starve_cnt + 1'b1;
  end

  assign wb_hold = !fifo_empty && (starve_cnt >= HOLD_AT);

  assign bus.md_ready_o = md_ready;
  assign bus.stall_o    = pending[bus.dec_rs1_i] | pending[bus.dec_rs2_i] | pending[bus.dec_rd_i];
  assign bus.wb_hold_o  = wb_hold;
  assign bus.WE3        = we3;
  assign bus.WD3        = wd3;
  assign bus.A3         = a3;

  issue_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    bus.issue_valid_i |-> !pending[bus.issue_rd_i]);

  hold_honoured: assert property (@(posedge clk) disable iff (!rst_n)
    wb_hold |=> (bus.wb_we_i == WE_NONE));

endmodule
